// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: encodes R/I/J requests into a 4-deep FIFO with a wrapping word address.
// Optional MIPS_ENC_ERR_EN: illegal kinds are dropped and raise a sticky err output.
module mips_instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [7:0]  out_addr,
    input  logic        flush
`ifdef MIPS_ENC_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int DATA_W = 32;

    function automatic logic [DATA_W-1:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [DATA_W-1:0] w;
        w = '0;
        case (kind)
            4'd0: w = {6'h00, rs, rt, rd, 5'b0, 6'h20};
            4'd1: w = {6'h00, rs, rt, rd, 5'b0, 6'h22};
            4'd2: w = {6'h00, rs, rt, rd, 5'b0, 6'h2A};
            4'd3: w = {6'h00, rs, rt, rd, 5'b0, 6'h1C};
            4'd4: w = {6'h23, rs, rt, imm};
            4'd5: w = {6'h2B, rs, rt, imm};
            4'd6: w = {6'h04, rs, rt, imm};
            4'd7: w = {6'h08, rs, rt, imm};
            4'd8: w = {6'h02, tgt};
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [DATA_W-1:0] mem_p0 [4];
    logic [DATA_W-1:0] enc_p0;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;

    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign req_ready = !full;
    assign out_valid = !empty;
    assign accept    = req_valid && !full;
    assign pop       = out_valid && out_ready;
    assign enc_p0    = encode(req_kind, req_rs, req_rt, req_rd, req_imm, req_target);

`ifdef MIPS_ENC_ERR_EN
    // Illegal kinds are consumed from the request side but never enter the FIFO.
    assign push = accept && (req_kind <= 4'd8);
`else
    assign push = accept;
`endif

    // Head is masked to zero when empty so stale storage never shows on the output.
    assign out_instr = empty ? '0 : mem_p0[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 2'd1;
                out_addr <= out_addr + 8'd1;
            end
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_p0[wr_ptr] <= enc_p0;
        end
    end

`ifdef MIPS_ENC_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (req_kind > 4'd8)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        flush;
`ifdef MIPS_ENC_ERR_EN
    logic        err;
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] exp_q[$];
    bit [7:0]  m_addr = 8'd0;
    bit        m_err  = 1'b0;

    always #5 clk = ~clk;

    mips_instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .req_target (req_target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .flush      (flush)
`ifdef MIPS_ENC_ERR_EN
        ,
        .err        (err)
`endif
    );

    // Field placement by shift-and-add arithmetic.
    function automatic bit [31:0] ref_enc(int unsigned k, int unsigned rs, int unsigned rt,
                                          int unsigned rd, int unsigned imm, int unsigned tgt);
        int unsigned fn[4] = '{32, 34, 42, 28};
        int unsigned op[4] = '{35, 43, 4, 8};
        if (k <= 3) return 32'((rs << 21) + (rt << 16) + (rd << 11) + fn[k]);
        if (k <= 7) return 32'((op[k-4] << 26) + (rs << 21) + (rt << 16) + imm);
        if (k == 8) return 32'((2 << 26) + tgt);
        return 32'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int sz;
        bit push, pop;
        sz   = exp_q.size();
        pop  = out_ready && (sz > 0);
        push = req_valid && (sz < 4);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_addr = 8'd0;
            m_err  = 1'b0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_addr++;
            end
            if (push) begin
                if (ERR_EN && req_kind > 4'd8) m_err = 1'b1;
                else exp_q.push_back(ref_enc(req_kind, req_rs, req_rt, req_rd, req_imm, req_target));
            end
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
        chk({tag, ".req_ready"}, req_ready, exp_q.size() < 4);
        chk({tag, ".out_addr"}, out_addr, m_addr);
        chk({tag, ".out_instr"}, out_instr, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
`ifdef MIPS_ENC_ERR_EN
        chk({tag, ".err"}, err, m_err);
`endif
    endtask

    task automatic set_fields(int unsigned k, int unsigned rs, int unsigned rt, int unsigned rd,
                              int unsigned imm, int unsigned tgt);
        req_kind   = 4'(k);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_imm    = 16'(imm);
        req_target = 26'(tgt);
    endtask

    task automatic rand_fields(int unsigned kmax);
        set_fields($urandom_range(0, kmax), $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic single(string tag, int unsigned k, int unsigned rs, int unsigned rt,
                          int unsigned rd, int unsigned imm, int unsigned tgt, bit [31:0] word);
        set_fields(k, rs, rt, rd, imm, tgt);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        rand_fields(15);
        check_state(tag);
        chk({tag, ".word"}, out_instr, word);
        chk({tag, ".valid"}, out_valid, 1'b1);
        cycle();
        check_state({tag, ".drain"});
    endtask

    initial begin
        bit [7:0] a_save;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;
        check_state("reset");
        chk("reset.instr0", out_instr, 32'd0);
        chk("reset.ready1", req_ready, 1'b1);

        out_ready = 1'b1;
        single("add", 0, 1, 2, 3, 16'h1234, 0, 32'h00221820);
        chk("add.addr_after", out_addr, 8'd1);
        single("lw", 4, 0, 8, 31, 16'h0004, 26'h3ffffff, 32'h8C080004);
        single("beq", 6, 4, 5, 7, 16'hFFFF, 0, 32'h1085FFFF);
        single("j", 8, 31, 31, 31, 16'hFFFF, 26'h0000010, 32'h08000010);

        // Backpressure: five back-to-back requests with the output stalled
        reset = 1'b1; cycle(); reset = 1'b0;
        out_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_fields(8);
            cycle();
            check_state("bp.fill");
            if (i == 3) chk("bp.full_ready", req_ready, 1'b0);
        end
        chk("bp.held_ready", req_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit acc;
            if (i < 4) chk("bp.addr_seq", out_addr, 8'(i));
            acc = req_valid && req_ready;
            cycle();
            if (acc) req_valid = 1'b0;
            check_state("bp.drain");
        end

        // Address wrap: 257 handshakes
        reset = 1'b1; cycle(); reset = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 258; i++) begin
            rand_fields(8);
            cycle();
            check_state("wrap");
            if (i == 256) chk("wrap.addr0", out_addr, 8'd0);
        end
        chk("wrap.addr_end", out_addr, 8'd1);

        // Flush with three words buffered
        req_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields(8);
            cycle();
        end
        check_state("flush.pre");
        a_save = out_addr;
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        req_valid = 1'b0;
        check_state("flush");
        chk("flush.valid0", out_valid, 1'b0);
        chk("flush.addr_kept", out_addr, a_save);

        // Reset mid-stream
        req_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(8);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = 1'b0;
        check_state("rst_mid");
        chk("rst_mid.addr0", out_addr, 8'd0);
        chk("rst_mid.empty", out_valid, 1'b0);

        // Illegal kind 12
        set_fields(12, 3, 4, 5, 16'h5555, 26'h1555555);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        check_state("illegal");
`ifdef MIPS_ENC_ERR_EN
        chk("illegal.err", err, 1'b1);
        chk("illegal.no_word", out_valid, 1'b0);
`else
        chk("illegal.valid", out_valid, 1'b1);
        chk("illegal.zero", out_instr, 32'd0);
`endif
        cycle();
        check_state("illegal.after");

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_fields(($urandom_range(0, 15) == 0) ? 15 : 8);
            cycle();
            check_state("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
